// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller.
// MC_JUMP_EN adds the JUMP state and makes opcode 000010 legal.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
`ifdef MC_JUMP_EN
      S_JUMP   = 4'd9,
`endif
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       memto_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic [1:0] alu_src_b;
      logic       illegal_op;
      logic       instr_done;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: return 1'b1;
`ifdef MC_JUMP_EN
         OP_J:                                return 1'b1;
`endif
         default:                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic [3:0] state;
   logic       illegal_op;
   logic       instr_done;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB,
             state, illegal_op, instr_done
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB,
             state, illegal_op, instr_done
   );
endinterface

// File: rtl/mc_output_decode.sv
// Moore control decode from state (plus mem_ready handshakes); all zero while enable is low.
// MC_JUMP_EN adds the JUMP row.
module mc_output_decode
   import mc_pkg::*;
(
   input  state_e     state,
   input  logic       mem_ready,
   input  logic [5:0] opcode,
   input  logic       enable,
   output ctrl_t      ctrl
);

   ctrl_t raw;

   always_comb begin
      // NOTE: every field gets a default first so no path through the case infers a latch.
      raw = '0;
      case (state)
         S_FETCH: begin
            raw.mem_read  = 1'b1;
            raw.alu_src_b = SRCB_FOUR;
            raw.ir_write  = mem_ready;
            raw.pc_write  = mem_ready;
         end
         S_DECODE: begin
            raw.alu_src_b  = SRCB_IMM_SH;
            raw.illegal_op = !op_legal(opcode);
            raw.instr_done = !op_legal(opcode);
         end
         S_MEMADR, S_ADDIEX: begin
            raw.alu_src_a = 1'b1;
            raw.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            raw.mem_read = 1'b1;
            raw.ior_d    = 1'b1;
         end
         S_MEMWR: begin
            raw.mem_write  = 1'b1;
            raw.ior_d      = 1'b1;
            raw.instr_done = mem_ready;
         end
         S_MEMWB: begin
            raw.memto_reg  = 1'b1;
            raw.reg_write  = 1'b1;
            raw.instr_done = 1'b1;
         end
         S_EXEC: begin
            raw.alu_src_a = 1'b1;
            raw.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            raw.reg_dst    = 1'b1;
            raw.reg_write  = 1'b1;
            raw.instr_done = 1'b1;
         end
         S_ADDIWB: begin
            raw.reg_write  = 1'b1;
            raw.instr_done = 1'b1;
         end
         S_BRANCH: begin
            raw.alu_src_a     = 1'b1;
            raw.alu_op        = ALUOP_SUB;
            raw.pc_write_cond = 1'b1;
            raw.pc_source     = PCSRC_ALUOUT;
            raw.instr_done    = 1'b1;
         end
`ifdef MC_JUMP_EN
         S_JUMP: begin
            raw.pc_write   = 1'b1;
            raw.pc_source  = PCSRC_JUMP;
            raw.instr_done = 1'b1;
         end
`endif
         default: ;
      endcase
      // Reset gating is combinational so nothing fires while reset is held.
      ctrl = enable ? raw : '0;
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: state register and next-state logic only.
// MC_JUMP_EN enables the j instruction (otherwise opcode 000010 is illegal).
module multicycle_control
   import mc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   multicycle_control_if.master  bus
);

   state_e state_q, state_d;
   ctrl_t  ctrl;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (bus.opcode == OP_LW)      state_d = S_MEMRD;
            else if (bus.opcode == OP_SW) state_d = S_MEMWR;
            else                          state_d = S_FETCH;
         end
         S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         // Write-back, branch, jump and any unused encoding all return to FETCH.
         default:  state_d = S_FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   mc_output_decode u_output_decode (
      .state     (state_q),
      .mem_ready (bus.mem_ready),
      .opcode    (bus.opcode),
      .enable    (reset),
      .ctrl      (ctrl)
   );

   assign bus.PCWrite     = ctrl.pc_write;
   assign bus.PCWriteCond = ctrl.pc_write_cond;
   assign bus.IorD        = ctrl.ior_d;
   assign bus.MemRead     = ctrl.mem_read;
   assign bus.MemWrite    = ctrl.mem_write;
   assign bus.IRWrite     = ctrl.ir_write;
   assign bus.MemtoReg    = ctrl.memto_reg;
   assign bus.RegWrite    = ctrl.reg_write;
   assign bus.RegDst      = ctrl.reg_dst;
   assign bus.ALUSrcA     = ctrl.alu_src_a;
   assign bus.PCSource    = ctrl.pc_source;
   assign bus.ALUOp       = ctrl.alu_op;
   assign bus.ALUSrcB     = ctrl.alu_src_b;
   assign bus.illegal_op  = ctrl.illegal_op;
   assign bus.instr_done  = ctrl.instr_done;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, corner sequences, randomized run
// against a path-based reference model. Honours MC_JUMP_EN.
module tb_multicycle_control;

   localparam logic [5:0] T_R    = 6'b000000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_BAD  = 6'b111111;

   typedef struct packed {
      logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
      logic       memto_reg, reg_write, reg_dst, alu_src_a;
      logic [1:0] pc_source, alu_op, alu_src_b;
      logic       illegal_op, instr_done;
   } outs_t;

   typedef struct {
      logic [5:0] op;
      int         lat;
      string      name;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   exp_q[$];

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic outs_t actual();
      outs_t o;
      o = '{bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
            bus.PCSource, bus.ALUOp, bus.ALUSrcB, bus.illegal_op, bus.instr_done};
      return o;
   endfunction

   function automatic bit is_wait_state(input int st);
      return st == 0 || st == 3 || st == 5;
   endfunction

   // Control table straight from the state description; done/illegal derived from path position.
   function automatic outs_t expect_out(input int st, input logic rdy, input bit last);
      outs_t o;
      o = '0;
      case (st)
         0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
         1:  o.alu_src_b = 2'b11;
         2, 10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         3:  begin o.mem_read = 1; o.ior_d = 1; end
         4:  begin o.memto_reg = 1; o.reg_write = 1; end
         5:  begin o.mem_write = 1; o.ior_d = 1; end
         6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
         7:  begin o.reg_dst = 1; o.reg_write = 1; end
         8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
         9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
         11: o.reg_write = 1;
         default: ;
      endcase
      o.instr_done = last && (!is_wait_state(st) || rdy);
      o.illegal_op = last && st == 1;
      return o;
   endfunction

   // Reference model: the sequence of states an instruction walks through without waits.
   task automatic load_path(input logic [5:0] op);
      exp_q = '{0, 1};
      case (op)
         T_LW:   begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
         T_SW:   begin exp_q.push_back(2); exp_q.push_back(5); end
         T_R:    begin exp_q.push_back(6); exp_q.push_back(7); end
         T_BEQ:  exp_q.push_back(8);
         T_ADDI: begin exp_q.push_back(10); exp_q.push_back(11); end
`ifdef MC_JUMP_EN
         T_J:    exp_q.push_back(9);
`endif
         default: ;
      endcase
   endtask

   task automatic apply(input logic [5:0] op, input logic rdy);
      @(negedge clk);
      bus.opcode    = op;
      bus.mem_ready = rdy;
      #1;
   endtask

   // Runs one instruction from FETCH; returns the cycle in which the DUT raised instr_done.
   task automatic run_instr(input logic [5:0] op, input int wait_pct, output int done_at);
      int   idx;
      int   cycles;
      int   st;
      logic rdy;
      bit   last;
      load_path(op);
      idx     = 0;
      cycles  = 0;
      done_at = -1;
      while (idx < exp_q.size()) begin
         st   = exp_q[idx];
         last = (idx == exp_q.size() - 1);
         rdy  = (wait_pct == 0 || cycles >= 20) ? 1'b1 : ($urandom_range(99) >= wait_pct);
         // Opcode is only meaningful while the IR holds it; scramble it elsewhere.
         apply((st == 1 || st == 2) ? op : 6'($urandom), rdy);
         check("state", 32'(bus.state), 32'(st));
         check("outputs", 32'(actual()), 32'(expect_out(st, rdy, last)));
         cycles++;
         if (bus.instr_done && done_at < 0) done_at = cycles;
         if (!(is_wait_state(st) && !rdy)) idx++;
      end
   endtask

   initial begin
      vec_t vecs[7];
      int   done_at;
      logic [5:0] op;

      vecs[0] = '{T_LW,   5, "lw"};
      vecs[1] = '{T_SW,   4, "sw"};
      vecs[2] = '{T_R,    4, "rtype"};
      vecs[3] = '{T_ADDI, 4, "addi"};
      vecs[4] = '{T_BEQ,  3, "beq"};
`ifdef MC_JUMP_EN
      vecs[5] = '{T_J,    3, "j"};
`else
      vecs[5] = '{T_J,    2, "j_illegal"};
`endif
      vecs[6] = '{T_BAD,  2, "illegal"};

      // Reset: everything gated to zero even with mem_ready high.
      bus.opcode    = T_LW;
      bus.mem_ready = 1'b1;
      #1 reset = 1'b0;
      #2;
      check("reset_state", 32'(bus.state), 32'd0);
      check("reset_outs", 32'(actual()), 32'd0);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      check("post_reset_fetch", 32'(actual()), 32'(expect_out(0, 1'b0, 1'b0)));

      // Directed table with no wait states.
      foreach (vecs[i]) begin
         run_instr(vecs[i].op, 0, done_at);
         check({"latency_", vecs[i].name}, 32'(done_at), 32'(vecs[i].lat));
      end

      // sw held in MEMWR for two wait cycles.
      apply(T_SW, 1'b1);
      apply(T_SW, 1'b1);
      apply(T_SW, 1'b1);
      for (int k = 0; k < 3; k++) begin
         apply(T_SW, k == 2);
         check("sw_wait_state", 32'(bus.state), 32'd5);
         check("sw_wait_memwrite", 32'(bus.MemWrite), 32'd1);
         check("sw_wait_done", 32'(bus.instr_done), 32'(k == 2));
      end
      apply(T_SW, 1'b0);
      check("sw_wait_then_fetch", 32'(bus.state), 32'd0);

      // Jump: supported with the macro, illegal without it.
      apply(T_J, 1'b1);
      apply(T_J, 1'b1);
`ifdef MC_JUMP_EN
      check("j_decode_legal", 32'(bus.illegal_op), 32'd0);
      apply(T_J, 1'b1);
      check("j_state", 32'(bus.state), 32'd9);
      check("j_pcsource", 32'(bus.PCSource), 32'd2);
      check("j_pcwrite", 32'(bus.PCWrite), 32'd1);
`else
      check("j_illegal", 32'(bus.illegal_op), 32'd1);
      apply(T_J, 1'b0);
      check("j_back_to_fetch", 32'(bus.state), 32'd0);
`endif
      apply(T_R, 1'b0);
      check("fetch_after_j", 32'(bus.state), 32'd0);

      // Reset in the middle of a MEMRD wait.
      apply(T_LW, 1'b1);
      apply(T_LW, 1'b1);
      apply(T_LW, 1'b1);
      apply(T_LW, 1'b0);
      check("memrd_wait_state", 32'(bus.state), 32'd3);
      reset = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      check("midwait_reset_outs", 32'(actual()), 32'd0);
      check("midwait_reset_state", 32'(bus.state), 32'd0);
      @(negedge clk);
      #1;
      check("held_reset_outs", 32'(actual()), 32'd0);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      check("release_state", 32'(bus.state), 32'd0);
      check("release_fetch", 32'(actual()), 32'(expect_out(0, 1'b0, 1'b0)));

      // Randomized instructions with random wait states.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(6))
            0: op = T_R;
            1: op = T_LW;
            2: op = T_SW;
            3: op = T_BEQ;
            4: op = T_ADDI;
            5: op = T_J;
            default: op = 6'($urandom);
         endcase
         run_instr(op, 30, done_at);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces FETCH.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory completes the current read or write this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls.
REQ-007 PCSource, ALUOp, ALUSrcB  output  2 each  datapath selects.
REQ-008 state  output  4  current state encoding, for debug.
REQ-009 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 instr_done  output  1  one-cycle pulse in the last cycle of each instruction.

Function
REQ-011 Encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-012 Opcodes SHALL be: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-013 Transitions SHALL be:
- FETCH->DECODE when mem_ready=1, else stay in FETCH.
- DECODE dispatch: lw/sw->MEMADR; R->EXEC; beq->BRANCH; addi->ADDIEX; j->JUMP; other->FETCH.
- MEMADR: lw->MEMRD, sw->MEMWR.
- MEMRD->MEMWB when mem_ready=1, else stay.
- MEMWR->FETCH when mem_ready=1, else stay.
- EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-014 Outputs SHALL be Moore decoded from state; any output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready.
- DECODE: ALUSrcB=11.
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
- MEMRD: MemRead=1, IorD=1.
- MEMWR: MemWrite=1, IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- EXEC: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
REQ-015 Latency with no wait states SHALL be: lw 5 cycles; sw, R, addi 4; beq, j 3.
REQ-016 Each wait cycle on mem_ready SHALL add exactly one cycle and hold all outputs stable.
REQ-017 illegal_op SHALL pulse for the DECODE cycle of an unsupported opcode, and the next state SHALL be FETCH.
REQ-018 instr_done SHALL be 1 in:
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP;
- MEMWR when mem_ready=1;
- DECODE on an illegal opcode.
REQ-019 opcode SHALL be sampled only in DECODE and MEMADR.

Reset
REQ-020 While reset=0, state SHALL be FETCH and every output SHALL be 0, with the gating applied combinationally.
REQ-021 Reset asserted in any state, including mid-wait, SHALL abandon the instruction without a PC, register or memory write.
REQ-022 The first cycle after release SHALL be FETCH with MemRead=1.

Configuration
REQ-023 Macro MC_JUMP_EN defined: j SHALL be supported as in REQ-013.
REQ-024 MC_JUMP_EN undefined: the JUMP state SHALL not exist, and opcode 000010 SHALL be illegal per REQ-017.

Structure
REQ-025 Package mc_pkg SHALL hold the state enum, opcode constants and ALUOp/PCSource/ALUSrcB constants.
REQ-026 Sub-module mc_output_decode SHALL map state and mem_ready to the control outputs combinationally.
REQ-027 The top level SHALL hold only the state register and the next-state logic.

Verification
REQ-028 lw with mem_ready tied to 1 -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 in cycle 5; instr_done once.
REQ-029 sw with mem_ready=0 for 2 cycles in MEMWR -> MemWrite=1 held for 3 cycles, then FETCH.
REQ-030 beq -> states 0,1,8; PCWriteCond=1 and PCSource=01 in cycle 3.
REQ-031 opcode 111111 -> illegal_op=1 in DECODE, then FETCH with no RegWrite or MemWrite.
REQ-032 reset=0 during MEMRD wait -> all outputs 0 immediately; FETCH after release.
REQ-033 j with and without MC_JUMP_EN -> PCSource=10 in cycle 3 with the macro; illegal_op=1 without it.
